// File: rtl/program_loader.sv
// Boot-time loader: takes a byte stream (16-bit word count, then MSB-first
// 32-bit words), writes it to memory from address 0 and releases the CPU when done.
module program_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_run,
    output logic                  load_err,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] LP_MEM_WORDS = 17'(MEM_WORDS);

    state_t                r_state;
    state_t                w_next;
    logic [15:0]           r_count;
    logic [31:0]           r_word;
    logic [1:0]            r_byte_idx;
    logic [ADDR_WIDTH-1:0] r_word_idx;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [15:0]           r_words_loaded;

    logic                  w_xfer;
    logic [15:0]           w_count_full;
    logic                  w_last_word;
    logic                  w_restart_ok;

    assign w_xfer       = in_valid && in_ready;
    assign w_count_full = {r_count[15:8], in_data};
    assign w_last_word  = (r_words_loaded + 16'd1) == r_count;
    assign w_restart_ok = restart && (r_state == S_DONE || r_state == S_ERR);

    // Every output is a decode of registered state, so no input reaches an output combinationally.
    assign in_ready     = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) || (r_state == S_DATA);
    assign mem_we       = (r_state == S_WRITE);
    assign cpu_run      = (r_state == S_DONE);
    assign load_err     = (r_state == S_ERR);
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_word;
    assign words_loaded = r_words_loaded;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_CNT_HI;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CNT_HI: if (w_xfer) w_next = S_CNT_LO;
            S_CNT_LO: begin
                if (w_xfer) begin
                    if ({1'b0, w_count_full} > LP_MEM_WORDS) w_next = S_ERR;
                    else if (w_count_full == 16'd0)          w_next = S_DONE;
                    else                                     w_next = S_DATA;
                end
            end
            S_DATA:   if (w_xfer && r_byte_idx == 2'd3) w_next = S_WRITE;
            S_WRITE:  w_next = w_last_word ? S_DONE : S_DATA;
            S_DONE:   if (restart) w_next = S_CNT_HI;
            S_ERR:    if (restart) w_next = S_CNT_HI;
            default:  w_next = S_CNT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count        <= '0;
            r_word         <= '0;
            r_byte_idx     <= '0;
            r_word_idx     <= '0;
            r_mem_addr     <= '0;
            r_words_loaded <= '0;
        end else begin
            if (w_xfer && r_state == S_CNT_HI) r_count[15:8] <= in_data;
            if (w_xfer && r_state == S_CNT_LO) r_count[7:0]  <= in_data;
            if (w_xfer && r_state == S_DATA) begin
                r_word     <= {r_word[23:0], in_data};
                r_byte_idx <= r_byte_idx + 2'd1;
                // Address is captured on entry to WRITE so it holds between writes.
                if (r_byte_idx == 2'd3) r_mem_addr <= r_word_idx;
            end
            if (r_state == S_WRITE) begin
                r_word_idx     <= r_word_idx + ADDR_WIDTH'(1);
                r_words_loaded <= r_words_loaded + 16'd1;
            end
            if (w_restart_ok) begin
                r_word_idx     <= '0;
                r_words_loaded <= '0;
                r_byte_idx     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes the expected memory writes,
// an independent monitor pops and compares them whenever mem_we is seen.
module tb_program_loader;

    localparam int AW        = 10;
    localparam int MEM_WORDS = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          restart;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_run;
    logic          load_err;
    logic [15:0]   words_loaded;

    program_loader #(.ADDR_WIDTH(AW), .MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .restart      (restart),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_run      (cpu_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t           exp_q[$];
    int            wr_cycles[$];
    logic [31:0]   img[$];
    logic [AW-1:0] hold_addr = '0;
    int            cyc       = 0;
    int            n_checks  = 0;
    int            n_fail    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pop on every write, plus interface rules checked each cycle.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (reset) begin
            if (mem_we) begin
                wr_cycles.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", mem_wdata, e.data);
                    hold_addr = e.addr;
                end
            end else begin
                check("addr_hold", 32'(mem_addr), 32'(hold_addr));
            end
            check("ready_rule", 32'(in_ready), 32'(!(mem_we || cpu_run || load_err)));
            check("run_err_excl", 32'(cpu_run && load_err), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            restart  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        restart  = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int w = 0; w < 40; w++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        n_fail++;
        $display("FAIL byte_accept_timeout: got no transfer expected byte 0x%0h accepted", b);
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax, input bit noise);
        for (int k = 3; k >= 0; k--)
            send_byte(w[8*k +: 8], $urandom_range(0, gapmax), noise);
    endtask

    // Reference: counts above capacity produce no writes; otherwise word i lands at address i.
    task automatic load(input int n, input int gapmax, input bit noise);
        logic [15:0] nn;
        nn = 16'(n);
        send_byte(nn[15:8], $urandom_range(0, gapmax), noise);
        send_byte(nn[7:0], $urandom_range(0, gapmax), noise);
        if (n > MEM_WORDS) return;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: AW'(i), data: img[i]});
            send_word(img[i], gapmax, noise);
        end
    endtask

    task automatic finish_load_check(input int n);
        @(negedge clk);
        check("run_during_final_write", 32'(cpu_run), 32'd0);
        @(negedge clk);
        check("run_after_final_write", 32'(cpu_run), 32'd1);
        check("words_loaded", 32'(words_loaded), 32'(n));
        check("ready_in_done", 32'(in_ready), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    task automatic rand_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        restart  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Back-to-back image: writes must be exactly 5 cycles apart.
        img = '{32'h20080005, 32'h2009000A, 32'h01095020};
        wr_cycles.delete();
        load(3, 0, 0);
        finish_load_check(3);
        check("wr_count", 32'(wr_cycles.size()), 32'd3);
        if (wr_cycles.size() == 3) begin
            check("wr_spacing_0_1", 32'(wr_cycles[1] - wr_cycles[0]), 32'd5);
            check("wr_spacing_1_2", 32'(wr_cycles[2] - wr_cycles[1]), 32'd5);
        end

        // Same image with gaps and stray restart pulses outside DONE/ERR.
        do_restart();
        check("restart_run_low", 32'(cpu_run), 32'd0);
        check("restart_ready", 32'(in_ready), 32'd1);
        check("restart_words_cleared", 32'(words_loaded), 32'd0);
        load(3, 3, 1);
        finish_load_check(3);

        // Empty image.
        do_restart();
        img.delete();
        load(0, 2, 0);
        @(negedge clk);
        check("n0_cpu_run", 32'(cpu_run), 32'd1);
        check("n0_load_err", 32'(load_err), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
            check("n0_bytes_refused", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check("n0_words_loaded", 32'(words_loaded), 32'd0);

        // Oversized count: error, no writes, recover with restart.
        @(posedge clk); #1;
        do_restart();
        load(16'h0401, 1, 0);
        @(negedge clk);
        check("err_load_err", 32'(load_err), 32'd1);
        check("err_cpu_run", 32'(cpu_run), 32'd0);
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("err_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        do_restart();
        check("err_cleared", 32'(load_err), 32'd0);
        check("err_restart_ready", 32'(in_ready), 32'd1);
        rand_img(1);
        load(1, 2, 0);
        finish_load_check(1);

        // Reset after 6 data bytes of an N=2 load.
        do_restart();
        rand_img(2);
        send_byte(8'h00, 0, 0);
        send_byte(8'h02, 0, 0);
        exp_q.push_back('{addr: AW'(0), data: img[0]});
        send_word(img[0], 1, 0);
        send_byte(img[1][31:24], 0, 0);
        send_byte(img[1][23:16], 0, 0);
        #2;
        reset     = 1'b0;
        hold_addr = '0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_cpu_run", 32'(cpu_run), 32'd0);
        check("abort_words_loaded", 32'(words_loaded), 32'd0);
        check("abort_scoreboard", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        rand_img(2);
        load(2, 1, 0);
        finish_load_check(2);

        // Restart from DONE and load a single known word.
        do_restart();
        check("done_restart_run_drop", 32'(cpu_run), 32'd0);
        img = '{32'hDEADBEEF};
        load(1, 0, 0);
        finish_load_check(1);

        repeat (5) @(negedge clk);
        check("final_scoreboard", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
